dly_cal_16: RTL



---
 rtl/dly_cal_16_pkg.sv | 25 ++
 rtl/dly_cal_16_dly01_16.sv | 23 ++
 rtl/dly_cal_16.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dly_cal_16_pkg.sv
// Shared definitions for the dly_cal_16 read-latency calibrator:
// FSM state encoding, window length and delay-setting width.
package dly_cal_16_pkg;

  // Window length equals the tap depth of the calibrated delay line.
  localparam int DLY_CAL_WIN = 16;
  // Width of a delay setting (0..15).
  localparam int DLY_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_PROBE,
    S_WIN,
    S_GAP,
    S_EVAL,
    S_FIN
  } state_t;

  // Two-bit counter that sticks at 3 once reached.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/dly_cal_16_dly01_16.sv
// dly01_16: 1..16 cycle synchronous delay line. Setting sel delays din by
// sel+1 cycles. The tap register is cleared by reset.
module dly01_16
  import dly_cal_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [DLY_W-1:0] sel,
  output logic             dout
);

  logic [DLY_CAL_WIN-1:0] taps_reg;

  // Shift the input through the taps; tap 0 holds din from one cycle ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) taps_reg <= '0;
    else     taps_reg <= {taps_reg[DLY_CAL_WIN-2:0], din};
  end

  assign dout = taps_reg[sel];

endmodule

// File: rtl/dly_cal_16.sv
// dly_cal_16: sweeps delay settings 0..15, probes an external round-trip
// path and a local dly01_16, and picks the single setting whose delayed
// probe matches the returned echo on every cycle of every window.
// Optional feature macro: DLY_CAL_MASK_EN (per-setting pass mask register).
module dly_cal_16
  import dly_cal_16_pkg::*;
#(
  parameter int REPEAT = 4,
  parameter int GUARD  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo,
  output logic             probe,
  output logic [DLY_W-1:0] dly,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [15:0]      match_mask
);

  // Idle cycles after each window so probes are spaced exactly GUARD apart.
  localparam int GAP_LEN = GUARD - (DLY_CAL_WIN + 1);

  state_t           state_reg, state_next;
  logic [15:0]      cyc_reg;
  logic [3:0]       rep_reg;
  logic             mism_reg;
  logic [1:0]       pass_reg;
  logic [DLY_W-1:0] res_reg;
  logic [DLY_W-1:0] dly_reg;
  logic             fail_reg;
  logic             line_out;
  logic [1:0]       pass_upd;
  logic [DLY_W-1:0] res_upd;
  logic             rep_more;

  dly01_16 u_line (
    .clk  (clk),
    .rst  (rst),
    .din  (probe),
    .sel  (dly_reg),
    .dout (line_out)
  );

  // Pass count and recorded setting including the setting being evaluated.
  assign pass_upd = mism_reg ? pass_reg : sat_inc(pass_reg);
  assign res_upd  = mism_reg ? res_reg  : dly_reg;
  assign rep_more = (rep_reg < 4'(REPEAT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SET;
      S_SET:   state_next = S_PROBE;
      S_PROBE: state_next = S_WIN;
      S_WIN: begin
        if (cyc_reg == 16'(DLY_CAL_WIN - 1)) begin
          if (GAP_LEN != 0) state_next = S_GAP;
          else              state_next = rep_more ? S_PROBE : S_EVAL;
        end
      end
      S_GAP: begin
        if (cyc_reg == 16'(GAP_LEN - 1))
          state_next = rep_more ? S_PROBE : S_EVAL;
      end
      S_EVAL:  state_next = (dly_reg == 4'hF) ? S_FIN : S_SET;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Decoded outputs.
  always_comb begin
    probe = (state_reg == S_PROBE);
    done  = (state_reg == S_FIN);
    busy  = (state_reg != S_IDLE) && (state_reg != S_FIN);
  end

  // Sweep datapath: counters, mismatch tracking, pass bookkeeping, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_reg  <= '0;
      rep_reg  <= '0;
      mism_reg <= 1'b0;
      pass_reg <= '0;
      res_reg  <= '0;
      dly_reg  <= '0;
      fail_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            fail_reg <= 1'b0;
            pass_reg <= '0;
            dly_reg  <= '0;
          end
        end
        S_SET: begin
          rep_reg  <= '0;
          mism_reg <= 1'b0;
        end
        S_PROBE: begin
          rep_reg <= rep_reg + 4'd1;
          cyc_reg <= '0;
        end
        S_WIN: begin
          if (echo != line_out) mism_reg <= 1'b1;
          cyc_reg <= (cyc_reg == 16'(DLY_CAL_WIN - 1)) ? 16'd0 : cyc_reg + 16'd1;
        end
        S_GAP: cyc_reg <= cyc_reg + 16'd1;
        S_EVAL: begin
          pass_reg <= pass_upd;
          res_reg  <= res_upd;
          if (dly_reg == 4'hF) begin
            // Result is settled here so it is valid alongside done.
            dly_reg  <= (pass_upd == 2'd1) ? res_upd : 4'd0;
            fail_reg <= (pass_upd != 2'd1);
          end else begin
            dly_reg <= dly_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dly  = dly_reg;
  assign fail = fail_reg;

`ifdef DLY_CAL_MASK_EN
  logic [15:0] mask_reg;

  // Record every setting that matched on all probes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask_reg <= '0;
    else if (state_reg == S_IDLE && start)
      mask_reg <= '0;
    else if (state_reg == S_EVAL && !mism_reg)
      mask_reg[dly_reg] <= 1'b1;
  end

  assign match_mask = mask_reg;
`else
  assign match_mask = '0;
`endif

endmodule
